// File: rtl/medio_sumador.sv
// Half adder: the building block of the full-adder cell.
// Two of these plus an OR gate form sumador_completo.
module medio_sumador (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/sumador_completo.sv
// 1-bit full adder with combinational St/Cout and registered copies St_q/Cout_q.
// Chain Cout -> Cin of successive instances to build ripple-carry adders.
module sumador_completo (
  input  logic clk,
  input  logic rst,
  input  logic Cin,
  input  logic A,
  input  logic B,
  output logic St,
  output logic Cout,
  output logic St_q,
  output logic Cout_q
);

  logic s1, c1, c2;
  logic st_d, cout_d;
  logic st_q, cout_q;

  // First stage adds the operands, second stage folds in the carry-in.
  medio_sumador u_ms_ab (
    .a_i (A),
    .b_i (B),
    .s_o (s1),
    .c_o (c1)
  );

  medio_sumador u_ms_cin (
    .a_i (s1),
    .b_i (Cin),
    .s_o (St),
    .c_o (c2)
  );

  // Both carries can never be 1 at once, so OR is sufficient.
  assign Cout = c1 | c2;

  always_comb begin
    // NOTE: defaults first so every path assigns st_d/cout_d and no latch is inferred.
    st_d   = St;
    cout_d = Cout;
    if (rst) begin
      st_d   = 1'b0;
      cout_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    st_q   <= st_d;
    cout_q <= cout_d;
  end

  assign St_q   = st_q;
  assign Cout_q = cout_q;

endmodule

// File: tb/tb_sumador_completo.sv
// Randomized scoreboard bench for sumador_completo: combinational table,
// registered outputs with reset, and a 4-bit ripple chain.
module tb_sumador_completo;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b0;
  logic Cin = 1'b0, A = 1'b0, B = 1'b0;
  logic St, Cout, St_q, Cout_q;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic st;
    logic cout;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_e;

  sumador_completo dut (
    .clk    (clk),
    .rst    (rst),
    .Cin    (Cin),
    .A      (A),
    .B      (B),
    .St     (St),
    .Cout   (Cout),
    .St_q   (St_q),
    .Cout_q (Cout_q)
  );

  // 4-bit ripple chain built from four cells
  logic [3:0] ca = 4'd0, cb = 4'd0, cs;
  logic [4:0] cc;
  logic       c_cin = 1'b0;
  logic [3:0] ch_sq, ch_cq;
  assign cc[0] = c_cin;

  for (genvar g = 0; g < 4; g++) begin : g_chain
    sumador_completo u_cell (
      .clk    (clk),
      .rst    (rst),
      .Cin    (cc[g]),
      .A      (ca[g]),
      .B      (cb[g]),
      .St     (cs[g]),
      .Cout   (cc[g+1]),
      .St_q   (ch_sq[g]),
      .Cout_q (ch_cq[g])
    );
  end

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  // Reference: plain integer addition of the three input bits.
  function automatic resp_t model(input logic cin, input logic a, input logic b);
    int    s;
    resp_t r;
    s      = int'(a) + int'(b) + int'(cin);
    r.st   = (s % 2) == 1;
    r.cout = s >= 2;
    return r;
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the expected registered response is queued.
  task automatic drive_cycle(input logic r, input logic cin, input logic a, input logic b);
    resp_t e;
    @(negedge clk);
    rst = r;
    Cin = cin;
    A   = a;
    B   = b;
    e   = model(cin, a, b);
    exp_q.push_back(r ? resp_t'(2'b00) : e);
    #1;
    check("st_comb_clocked", {4'd0, St}, {4'd0, e.st});
    check("cout_comb_clocked", {4'd0, Cout}, {4'd0, e.cout});
    @(posedge clk);
  endtask

  // Monitor: each rising edge, compare registered outputs with the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("st_q", {4'd0, St_q}, {4'd0, mon_e.st});
      check("cout_q", {4'd0, Cout_q}, {4'd0, mon_e.cout});
    end
  end

  initial begin
    resp_t    e;
    logic [2:0] code;
    int       bound;

    // Exhaustive table with clock held low, first with rst=0 then rst=1.
    for (int r = 0; r < 2; r++) begin
      rst = r[0];
      for (int i = 0; i < 8; i++) begin
        code = i[2:0];
        {Cin, A, B} = code;
        #10;
        e = model(code[2], code[1], code[0]);
        check(r == 0 ? "st_table" : "st_table_rst", {4'd0, St}, {4'd0, e.st});
        check(r == 0 ? "cout_table" : "cout_table_rst", {4'd0, Cout}, {4'd0, e.cout});
      end
    end
    rst = 1'b0;

    clk_en = 1'b1;

    // Reset with inputs 111 for two edges
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1);
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b1);

    // Pipeline: 101 then 100
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);

    // Random traffic with a single-cycle reset in the middle
    for (int i = 0; i < 40; i++) begin
      drive_cycle(i == 20, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Ripple chain: directed vector then random ones
    ca = 4'b1011; cb = 4'b0110; c_cin = 1'b1;
    #10;
    check("chain_sum", {1'b0, cs}, 5'b00010);
    check("chain_cout", {4'd0, cc[4]}, 5'd1);
    for (int i = 0; i < 12; i++) begin
      logic [4:0] total;
      ca    = 4'($urandom);
      cb    = 4'($urandom);
      c_cin = 1'($urandom);
      total = 5'(ca) + 5'(cb) + 5'(c_cin);
      #10;
      check("chain_rand", {cc[4], cs}, total);
    end

    // Drain the scoreboard within a bounded number of edges
    bound = 0;
    while (exp_q.size() > 0 && bound < 10) begin
      @(posedge clk);
      bound++;
    end
    #2;
    check("scoreboard_drained", 5'(exp_q.size()), 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
